// File: rtl/ras_ckpt_pkg.sv
// rtl/ras_ckpt_pkg.sv - shared widths and checkpoint record for the return address stack
// The record carries tos only when RAS_TOS_REPAIR_EN is defined.
package ras_ckpt_pkg;

   localparam int RAS_ENTRIES    = 8;
   localparam int RAS_ADDR_W     = 32;
   localparam int RAS_CKPT_DEPTH = 8;

   localparam int RAS_IDX_W      = $clog2(RAS_ENTRIES);
   localparam int RAS_CNT_W      = RAS_IDX_W + 1;
   localparam int RAS_CKPT_PTR_W = $clog2(RAS_CKPT_DEPTH);

   typedef struct packed {
      logic [RAS_IDX_W-1:0]  idx;
      logic [RAS_CNT_W-1:0]  cnt;
`ifdef RAS_TOS_REPAIR_EN
      logic [RAS_ADDR_W-1:0] tos;
`endif
   } ras_ckpt_t;

endpackage

// File: rtl/lutram_1w_1r.sv
// rtl/lutram_1w_1r.sv - distributed RAM, one synchronous write port, one asynchronous read port
// Contents are not reset.
module lutram_1w_1r #(
   parameter type DATA_TYPE = logic,
   parameter int  DEPTH     = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  DATA_TYPE                 wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output DATA_TYPE                 rdata
);

   DATA_TYPE mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ras_ckpt_fifo.sv
// rtl/ras_ckpt_fifo.sv - checkpoint FIFO for the return address stack
// Full flag is registered from the post-update count; clear wins over push and pop.
module ras_ckpt_fifo
   import ras_ckpt_pkg::*;
#(
   parameter int DEPTH = RAS_CKPT_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  ras_ckpt_t data_in,
   input  logic      pop,
   input  logic      clear,
   output ras_ckpt_t data_out,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = $clog2(DEPTH);

   ras_ckpt_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count, count_n;
   logic             full_q;

   always_comb begin
      count_n = count;
      if (clear) begin
         count_n = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
      end else begin
         count  <= count_n;
         full_q <= (count_n == (PTR_W+1)'(DEPTH));
         if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= data_in;
   end

   assign data_out = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = full_q;

endmodule

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - return address stack with branch checkpoints and flush restore
// Define RAS_TOS_REPAIR_EN to also checkpoint and rewrite the top-of-stack entry on flush.
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int ENTRIES    = RAS_ENTRIES,
   parameter int ADDR_W     = RAS_ADDR_W,
   parameter int CKPT_DEPTH = RAS_CKPT_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] new_addr,
   input  logic              branch_fetched,
   input  logic              branch_retired,
   input  logic              fetch_flush,
   output logic [ADDR_W-1:0] addr,
   output logic              pred_valid,
   output logic              ckpt_full
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   logic [IDX_W-1:0]  idx, idx_n, waddr;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              we;
   logic [ADDR_W-1:0] wdata;
   ras_ckpt_t         ck_in, ck_head;
   logic              ck_push, ck_pop, ck_full, ck_empty;

   // A full queue still accepts a checkpoint when a retire frees a slot the same cycle.
   assign ck_pop  = branch_retired & ~fetch_flush & ~ck_empty;
   assign ck_push = branch_fetched & ~fetch_flush & (~ck_full | ck_pop);

   always_comb begin
      ck_in     = '0;
      ck_in.idx = idx;
      ck_in.cnt = cnt;
`ifdef RAS_TOS_REPAIR_EN
      ck_in.tos = addr;
`endif
   end

   always_comb begin
      idx_n = idx;
      cnt_n = cnt;
      we    = 1'b0;
      waddr = idx;
      wdata = new_addr;
      if (fetch_flush) begin
         if (!ck_empty) begin
            idx_n = ck_head.idx;
            cnt_n = ck_head.cnt;
`ifdef RAS_TOS_REPAIR_EN
            we    = 1'b1;
            waddr = ck_head.idx;
            wdata = ck_head.tos;
`endif
         end
      end else if (push && pop) begin
         we = 1'b1;
         if (cnt == '0) cnt_n = CNT_W'(1);
      end else if (push) begin
         we    = 1'b1;
         waddr = idx + 1'b1;
         idx_n = idx + 1'b1;
         if (cnt != CNT_W'(ENTRIES)) cnt_n = cnt + 1'b1;
      end else if (pop && cnt != '0) begin
         idx_n = idx - 1'b1;
         cnt_n = cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         cnt <= '0;
      end else begin
         idx <= idx_n;
         cnt <= cnt_n;
      end
   end

   lutram_1w_1r #(
      .DATA_TYPE (logic [ADDR_W-1:0]),
      .DEPTH     (ENTRIES)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (idx),
      .rdata (addr)
   );

   ras_ckpt_fifo #(
      .DEPTH (CKPT_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ck_push),
      .data_in  (ck_in),
      .pop      (ck_pop),
      .clear    (fetch_flush),
      .data_out (ck_head),
      .full     (ck_full),
      .empty    (ck_empty)
   );

   assign pred_valid = (cnt != '0);
   assign ckpt_full  = ck_full;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - scoreboard bench for ras_ckpt against a queue-based stack model
// Expectations for RAS_TOS_REPAIR_EN follow the same macro.
module tb_ras_ckpt;

   localparam int N  = 8;
   localparam int CD = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0, pop = 1'b0;
   logic [31:0] new_addr = '0;
   logic        branch_fetched = 1'b0, branch_retired = 1'b0, fetch_flush = 1'b0;
   logic [31:0] addr;
   logic        pred_valid, ckpt_full;

   ras_ckpt dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (push),
      .pop            (pop),
      .new_addr       (new_addr),
      .branch_fetched (branch_fetched),
      .branch_retired (branch_retired),
      .fetch_flush    (fetch_flush),
      .addr           (addr),
      .pred_valid     (pred_valid),
      .ckpt_full      (ckpt_full)
   );

   always #5 clk = ~clk;

   typedef struct { int top; int depth; logic [31:0] tos; } ck_t;
   typedef struct { logic pv; logic full; logic [31:0] a; } exp_t;

   logic [31:0] m_ram [N];
   int          m_top = 0;
   int          m_depth = 0;
   ck_t         m_ck [$];
   exp_t        exp_q [$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: one expectation per clocked cycle, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pred_valid", {31'b0, pred_valid}, {31'b0, e.pv});
            check("ckpt_full", {31'b0, ckpt_full}, {31'b0, e.full});
            if (e.pv) check("addr", addr, e.a);
         end
      end
   end

   task automatic step(input logic p, input logic o, input logic [31:0] a,
                       input logic bf, input logic br, input logic ff);
      exp_t e;
      ck_t  c;
      bit   deq, was_full;
      @(negedge clk);
      push = p; pop = o; new_addr = a;
      branch_fetched = bf; branch_retired = br; fetch_flush = ff;
      if (ff) begin
         if (m_ck.size() > 0) begin
            c = m_ck[0];
            m_top = c.top;
            m_depth = c.depth;
`ifdef RAS_TOS_REPAIR_EN
            m_ram[m_top] = c.tos;
`endif
         end
         m_ck.delete();
      end else begin
         was_full = (m_ck.size() == CD);
         deq = br && (m_ck.size() > 0);
         c.top = m_top; c.depth = m_depth; c.tos = m_ram[m_top];
         if (deq) void'(m_ck.pop_front());
         if (bf && (!was_full || deq)) m_ck.push_back(c);
         if (p && o) begin
            m_ram[m_top] = a;
            if (m_depth == 0) m_depth = 1;
         end else if (p) begin
            m_top = (m_top + 1) % N;
            m_ram[m_top] = a;
            if (m_depth < N) m_depth++;
         end else if (o && m_depth > 0) begin
            m_top = (m_top + N - 1) % N;
            m_depth--;
         end
      end
      e.pv = (m_depth > 0);
      e.full = (m_ck.size() == CD);
      e.a = m_ram[m_top];
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_ram[i] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle();

      // basic LIFO order, then an extra pop on the empty stack
      step(1, 0, 32'h100, 0, 0, 0);
      step(1, 0, 32'h200, 0, 0, 0);
      step(1, 0, 32'h300, 0, 0, 0);
      repeat (4) step(0, 1, 32'h0, 0, 0, 0);
      step(1, 0, 32'h7, 0, 0, 0);
      step(0, 1, 32'h0, 0, 0, 0);

      // overflow: more pushes than entries, then drain with wrap
      for (int i = 1; i <= N + 1; i++) step(1, 0, 32'(i * 16), 0, 0, 0);
      repeat (N + 1) step(0, 1, 32'h0, 0, 0, 0);

      // flush restore after wrong-path pops
      step(1, 0, 32'hA000, 0, 0, 0);
      step(0, 0, 32'h0, 1, 0, 0);
      step(0, 1, 32'h0, 0, 0, 0);
      step(0, 1, 32'h0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 1);
      idle();

      // wrong-path push+pop overwrite, then flush
      step(1, 0, 32'hA001, 0, 0, 0);
      step(0, 0, 32'h0, 1, 0, 0);
      step(1, 1, 32'hBAD, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 1);
      idle();

      // checkpoint queue limits: fill, drop, retire, refill-with-retire, flush
      for (int i = 0; i < CD + 1; i++) step(1, 0, 32'(32'hC00 + i), 1, 0, 0);
      step(0, 0, 32'h0, 0, 1, 0);
      step(0, 0, 32'h0, 1, 0, 0);
      step(0, 0, 32'h0, 1, 1, 0);
      step(0, 1, 32'h0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 1);
      idle();

      // flush wins over a simultaneous push
      step(1, 0, 32'hD00, 1, 0, 0);
      step(1, 0, 32'hD01, 0, 0, 0);
      step(1, 0, 32'hEEE, 1, 1, 1);
      idle();

      // flush with an empty queue holds state
      step(1, 1, 32'hF00, 0, 0, 1);
      idle();

      repeat (800) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0);
      end
      idle();

      // asynchronous reset between edges with a full checkpoint queue
      for (int i = 0; i < CD; i++) step(1, 0, 32'(32'h5500 + i), 1, 0, 0);
      @(negedge clk);
      push = 0; pop = 0; branch_fetched = 0; branch_retired = 0; fetch_flush = 0;
      check("full_before_reset", {31'b0, ckpt_full}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_pred_valid", {31'b0, pred_valid}, 32'd0);
      check("async_ckpt_full", {31'b0, ckpt_full}, 32'd0);
      m_top = 0; m_depth = 0; m_ck.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      step(1, 0, 32'h1234, 0, 0, 0);
      step(0, 1, 32'h0, 0, 0, 0);
      idle();

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
